// File: rtl/mesh_loader.sv
// Mesh stream loader: parses V, vertices, F, faces, terminator from SPI words and stores them to RAM.
// Optional `MESH_LOADER_BOUNDS_CHECK_EN rejects counts that would overrun the RAM.
module mesh_loader #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  word_valid,
    input  logic [31:0]           word_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [31:0]           vertex_count,
    output logic [31:0]           face_count,
    output logic                  load_done,
    output logic                  load_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VCOUNT,
        S_VERTS,
        S_FCOUNT,
        S_FACES,
        S_TERM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [33:0]           remaining_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_wdata_q;
    logic [31:0]           vertex_count_q;
    logic [31:0]           face_count_q;
    logic                  load_done_q;
    logic                  load_error_q;

    logic [33:0]           rem_load_d;
    logic                  v_reject_d;
    logic                  f_reject_d;
    logic                  store_d;

`ifdef MESH_LOADER_BOUNDS_CHECK_EN
    localparam logic [35:0] DEPTH = 36'd1 << ADDR_WIDTH;
`endif

    always_comb begin
        rem_load_d = {2'b00, word_data} + {1'b0, word_data, 1'b0};
        v_reject_d = 1'b0;
        f_reject_d = 1'b0;
`ifdef MESH_LOADER_BOUNDS_CHECK_EN
        v_reject_d = ({2'b00, rem_load_d} + 36'd1) > (DEPTH - 36'd1);
        f_reject_d = (36'(addr_q) + {2'b00, rem_load_d} + 36'd1) > DEPTH;
`endif
        store_d = 1'b0;
        if (enable && word_valid) begin
            case (state_q)
                S_VCOUNT:         store_d = !v_reject_d;
                S_FCOUNT:         store_d = !f_reject_d;
                S_VERTS, S_FACES: store_d = 1'b1;
                default:          store_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            remaining_q    <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            vertex_count_q <= '0;
            face_count_q   <= '0;
            load_done_q    <= 1'b0;
            load_error_q   <= 1'b0;
        end else begin
            // Write path is decoupled from state sequencing; a write accepted
            // last cycle is already on the outputs when enable drops.
            mem_we_q <= store_d;
            if (store_d) begin
                mem_addr_q  <= addr_q;
                mem_wdata_q <= word_data;
                addr_q      <= addr_q + 1'b1;
            end

            if (!enable) begin
                state_q      <= S_IDLE;
                load_done_q  <= 1'b0;
                load_error_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q     <= S_VCOUNT;
                        addr_q      <= '0;
                        remaining_q <= '0;
                    end
                    S_VCOUNT: begin
                        if (word_valid) begin
                            vertex_count_q <= word_data;
                            if (v_reject_d) begin
                                state_q      <= S_ERROR;
                                load_error_q <= 1'b1;
                            end else begin
                                remaining_q <= rem_load_d;
                                state_q     <= (word_data == '0) ? S_FCOUNT : S_VERTS;
                            end
                        end
                    end
                    S_VERTS: begin
                        if (word_valid) begin
                            remaining_q <= remaining_q - 34'd1;
                            if (remaining_q == 34'd1) state_q <= S_FCOUNT;
                        end
                    end
                    S_FCOUNT: begin
                        if (word_valid) begin
                            face_count_q <= word_data;
                            if (f_reject_d) begin
                                state_q      <= S_ERROR;
                                load_error_q <= 1'b1;
                            end else begin
                                remaining_q <= rem_load_d;
                                state_q     <= (word_data == '0) ? S_TERM : S_FACES;
                            end
                        end
                    end
                    S_FACES: begin
                        if (word_valid) begin
                            remaining_q <= remaining_q - 34'd1;
                            if (remaining_q == 34'd1) state_q <= S_TERM;
                        end
                    end
                    S_TERM: begin
                        if (word_valid) begin
                            if (word_data == '1) begin
                                state_q     <= S_DONE;
                                load_done_q <= 1'b1;
                            end else begin
                                state_q      <= S_ERROR;
                                load_error_q <= 1'b1;
                            end
                        end
                    end
                    S_DONE:  state_q <= S_DONE;
                    S_ERROR: state_q <= S_ERROR;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign vertex_count = vertex_count_q;
    assign face_count   = face_count_q;
    assign load_done    = load_done_q;
    assign load_error   = load_error_q;

endmodule

// File: tb/tb_mesh_loader.sv
// Scoreboard bench for mesh_loader: directed cases plus randomized streams against a stream-level model.
module tb_mesh_loader;

    localparam int AW = 11;
    localparam longint DEPTH = longint'(1) << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          word_valid;
    logic [31:0]   word_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   vertex_count;
    logic [31:0]   face_count;
    logic          load_done;
    logic          load_error;

    mesh_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .word_valid(word_valid), .word_data(word_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .vertex_count(vertex_count), .face_count(face_count),
        .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] stim_q[$];
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual_addr=%0h actual_data=%0h expected=none", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 64'(mem_addr), 64'(e.a));
                check("write_data", 64'(mem_wdata), 64'(e.d));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, 64'(mem_we), 64'd0);
        check({tag, "_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_vcount"}, 64'(vertex_count), 64'd0);
        check({tag, "_fcount"}, 64'(face_count), 64'd0);
        check({tag, "_done"}, 64'(load_done), 64'd0);
        check({tag, "_error"}, 64'(load_error), 64'd0);
    endtask

    // Model: stored words are the first (3V+1)+(3F+1) of the stream at addresses 0,1,2.. mod depth;
    // the following word must be all-ones for success.
    task automatic run_stream(input int gap_max);
        longint v, f, nv, nstore;
        logic [31:0] term;
        bit exp_done, chk_f;
        v = longint'(stim_q[0]);
        nv = 3 * v + 1;
        f = longint'(stim_q[nv]);
        nstore = nv + 3 * f + 1;
        term = stim_q[nstore];
        exp_done = (term == 32'hFFFF_FFFF);
        chk_f = 1'b1;
`ifdef MESH_LOADER_BOUNDS_CHECK_EN
        if (nv > DEPTH - 1) begin
            nstore = 0; exp_done = 1'b0; chk_f = 1'b0;
        end else if (nv + 3 * f + 1 > DEPTH) begin
            nstore = nv; exp_done = 1'b0;
        end
`endif
        restart();
        for (int i = 0; i < stim_q.size(); i++) begin
            if (i < nstore) exp_q.push_back('{a: AW'(longint'(i) % DEPTH), d: stim_q[i]});
            word_valid = 1'b1;
            word_data  = stim_q[i];
            step();
            word_valid = 1'b0;
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) step();
        end
        repeat (4) step();
        check("drain", 64'(exp_q.size()), 64'd0);
        check("load_done", 64'(load_done), 64'(exp_done));
        check("load_error", 64'(load_error), 64'(!exp_done));
        check("vertex_count", 64'(vertex_count), 64'(v));
        if (chk_f) check("face_count", 64'(face_count), 64'(f));
    endtask

    task automatic build(input int v, input int f, input bit good_term);
        stim_q.delete();
        stim_q.push_back(32'(v));
        for (int i = 0; i < 3 * v; i++) stim_q.push_back($urandom);
        stim_q.push_back(32'(f));
        for (int i = 0; i < 3 * f; i++) stim_q.push_back($urandom);
        stim_q.push_back(good_term ? 32'hFFFF_FFFF : ($urandom & 32'hFFFF_FFFE));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; word_valid = 1'b0; word_data = '0;
        repeat (3) step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();

        // V=1, F=1 directed stream
        stim_q = '{32'd1, 32'hA, 32'hB, 32'hC, 32'd1, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF};
        run_stream(0);

        // word_valid while DONE must be ignored and status held
        for (int i = 0; i < 3; i++) begin
            word_valid = 1'b1; word_data = $urandom; step();
        end
        word_valid = 1'b0;
        repeat (2) step();
        check("done_hold", 64'(load_done), 64'd1);

        // empty mesh
        stim_q = '{32'd0, 32'd0, 32'hFFFF_FFFF};
        run_stream(1);

        // bad terminator
        stim_q = '{32'd1, 32'h11, 32'h22, 32'h33, 32'd0, 32'h1234_5678};
        run_stream(0);

        // abort after three words of a V=2 stream
        restart();
        stim_q = '{32'd2, 32'hAAAA_0001, 32'hAAAA_0002};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{a: AW'(i), d: stim_q[i]});
            word_valid = 1'b1; word_data = stim_q[i]; step();
        end
        word_valid = 1'b0;
        enable = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            word_valid = 1'b1; word_data = $urandom; step();
        end
        word_valid = 1'b0;
        repeat (2) step();
        check("abort_drain", 64'(exp_q.size()), 64'd0);
        check("abort_done", 64'(load_done), 64'd0);
        check("abort_error", 64'(load_error), 64'd0);
        check("abort_vcount_kept", 64'(vertex_count), 64'd2);

        // reload after abort starts from address 0
        build(2, 1, 1'b1);
        run_stream(0);

        // randomized streams, mixing back-to-back and gapped delivery
        for (int n = 0; n < 24; n++) begin
            build($urandom_range(0, 4), $urandom_range(0, 4), ($urandom_range(0, 3) != 0));
            run_stream((n % 3 == 0) ? 0 : 2);
        end

        // oversized vertex block: wraps by default, rejected with the bounds check
        build(700, 0, 1'b1);
        run_stream(0);

        // reset dominates enable and word_valid
        reset = 1'b1; enable = 1'b1; word_valid = 1'b1; word_data = 32'd5;
        step();
        check_reset_outputs("reset_prio");
        reset = 1'b0; word_valid = 1'b0;
        repeat (3) step();
        check("post_reset_drain", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
